// File: rtl/apb_csr_slave_if.sv
// APB3 completer bus bundle for apb_csr_slave.
// APB_CSR_PSTRB_EN adds the APB4 pstrb byte strobes.
interface apb_csr_slave_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
`ifdef APB_CSR_PSTRB_EN
  logic [DATA_W/8-1:0] pstrb;
`endif
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
`ifdef APB_CSR_PSTRB_EN
    output pstrb,
`endif
    output psel, penable, pwrite,
    output paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
`ifdef APB_CSR_PSTRB_EN
    input  pstrb,
`endif
    input  psel, penable, pwrite,
    input  paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_csr_slave.sv
// APB3 CSR completer: NUM_RW config regs, NUM_RO status words.
// APB_CSR_PSTRB_EN enables APB4 byte strobes on writes.
module apb_csr_slave #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int NUM_RW      = 8,
  parameter int NUM_RO      = 4,
  parameter int WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  apb_csr_slave_if.slave           bus,
  output logic [NUM_RW*DATA_W-1:0] cfg_o,
  output logic [NUM_RW-1:0]        cfg_wr_pulse,
  input  logic [NUM_RO*DATA_W-1:0] sts_i
);
  localparam int NB   = DATA_W / 8;
  localparam int BSH  = $clog2(NB);
  localparam int NREG = NUM_RW + NUM_RO;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state_q, state_d, phase;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cfg_q [NUM_RW];
  logic [DATA_W-1:0] cfg_d [NUM_RW];
  logic [NUM_RW-1:0] pulse_q, pulse_d;
  logic [ADDR_W-1:0] idx;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] rd;
  logic              mis, oor, ro_wr, strb_err;
  logic              err, done, wr_ok;

  // FSM state and wait-state counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Current bus phase, completion and next state.
  // state_q holds the phase of the previous cycle, so the
  // access phase is recognised in the same cycle penable
  // rises and back-to-back transfers lose no cycle.
  always_comb begin
    phase = IDLE;
    if (bus.psel) begin
      if (!bus.penable) begin
        phase = SETUP;
      end else if (state_q != IDLE) begin
        phase = ACCESS;
      end
    end
    done    = (phase == ACCESS) &&
              (cnt_q == 4'(WAIT_STATES));
    state_d = done ? IDLE : phase;
    cnt_d   = (phase == ACCESS && !done) ?
              cnt_q + 4'd1 : 4'd0;
  end

  // Address decode and error classification
  always_comb begin
    idx   = bus.paddr >> BSH;
    mis   = (bus.paddr & ADDR_W'(NB - 1)) != '0;
    oor   = idx >= ADDR_W'(NREG);
    ro_wr = bus.pwrite && (idx >= ADDR_W'(NUM_RW));
`ifdef APB_CSR_PSTRB_EN
    be       = bus.pstrb;
    strb_err = !bus.pwrite && (bus.pstrb != '0);
`else
    be       = '1;
    strb_err = 1'b0;
`endif
    err   = mis | oor | ro_wr | strb_err;
    wr_ok = done && bus.pwrite && !err && (be != '0);
  end

  // Read mux over config regs and live status words
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (idx == ADDR_W'(i)) rd = cfg_q[i];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (idx == ADDR_W'(NUM_RW + j)) begin
        rd = sts_i[j*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.pready  = done;
  assign bus.pslverr = done && err;
  assign bus.prdata  = (done && !err && !bus.pwrite) ?
                       rd : '0;

  // Byte-merged register update and write pulse
  always_comb begin
    cfg_d   = cfg_q;
    pulse_d = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (wr_ok && idx == ADDR_W'(i)) begin
        pulse_d[i] = 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (be[b]) begin
            cfg_d[i][b*8 +: 8] = bus.pwdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Config registers and pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RW; i++) begin
        cfg_q[i] <= RESET_VAL;
      end
      pulse_q <= '0;
    end else begin
      cfg_q   <= cfg_d;
      pulse_q <= pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_cfg
    assign cfg_o[g*DATA_W +: DATA_W] = cfg_q[g];
  end

  assign cfg_wr_pulse = pulse_q;
endmodule

// File: tb/tb_apb_csr_slave.sv
// Testbench for apb_csr_slave: table-driven APB transfers
// with a response scoreboard, plus corner-case sequences.
module tb_apb_csr_slave;
  localparam int WS = 1;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [7:0]  exp_pulse;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } sb_t;

  logic         clk;
  logic         rst;
  logic [255:0] cfg1, cfg0;
  logic [7:0]   pulse1, pulse0;
  logic [127:0] sts;
  logic [31:0]  model [8];
  vec_t         vecs [$];
  vec_t         svecs [$];
  sb_t          sbq [$];
  sb_t          mon_e;
  int           checks;
  int           errors;

  apb_csr_slave_if #(.ADDR_W(16), .DATA_W(32)) b1 ();
  apb_csr_slave_if #(.ADDR_W(16), .DATA_W(32)) b0 ();

  apb_csr_slave #(.WAIT_STATES(WS)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .bus          (b1),
    .cfg_o        (cfg1),
    .cfg_wr_pulse (pulse1),
    .sts_i        (sts)
  );

  apb_csr_slave #(.WAIT_STATES(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .bus          (b0),
    .cfg_o        (cfg0),
    .cfg_wr_pulse (pulse0),
    .sts_i        (sts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop expected response on each completion
  always @(negedge clk) begin
    if (!rst && b1.psel) begin
      if (b1.penable && b1.pready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got completion expected none");
        end else begin
          mon_e = sbq.pop_front();
          chk("prdata", b1.prdata, mon_e.rd);
          chk("pslverr", {31'b0, b1.pslverr},
              {31'b0, mon_e.err});
        end
      end else if (b1.pslverr !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL pslverr_idle: got %b expected 0",
                 b1.pslverr);
      end
    end
  end

  task automatic add(ref vec_t q [$], input logic wr,
                     input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] erd,
                     input logic eerr, input logic [7:0] ep);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.strb = s;
    v.exp_rd = erd; v.exp_err = eerr; v.exp_pulse = ep;
    q.push_back(v);
  endtask

  task automatic xfer(input logic wr, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] erd, input logic eerr);
    int  n;
    sb_t e;
    @(posedge clk); #1;
    b1.psel = 1'b1; b1.penable = 1'b0;
    b1.pwrite = wr; b1.paddr = a; b1.pwdata = d;
`ifdef APB_CSR_PSTRB_EN
    b1.pstrb = s;
`else
    if (s === 4'hx) $display("note: strb unknown");
`endif
    e.rd = erd; e.err = eerr;
    sbq.push_back(e);
    @(posedge clk); #1;
    b1.penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b1.pready !== 1'b1 && n < 16);
    chk($sformatf("latency@%h", a), n, WS + 1);
    if (n >= 16) void'(sbq.pop_back());
    @(posedge clk); #1;
    b1.psel = 1'b0; b1.penable = 1'b0;
  endtask

  task automatic chk_cfg();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cfg%0d", i), cfg1[i*32 +: 32], model[i]);
    end
  endtask

  task automatic run_vec(input vec_t v);
    xfer(v.wr, v.addr, v.wdata, v.strb, v.exp_rd, v.exp_err);
    if (v.wr && !v.exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (v.strb[b]) model[v.addr[4:2]][b*8 +: 8] =
                         v.wdata[b*8 +: 8];
      end
    end
    @(negedge clk);
    chk($sformatf("pulse@%h", v.addr), {24'b0, pulse1},
        {24'b0, v.exp_pulse});
    chk_cfg();
    @(negedge clk);
    chk("pulse_clr", {24'b0, pulse1}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic idle_rdy;
    checks = 0;
    errors = 0;
    sts = {32'h0BAD_F00D, 32'hCAFE_0002,
           32'h1234_5678, 32'hDEAD_BEEF};
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    b1.psel = 0; b1.penable = 0; b1.pwrite = 0;
    b1.paddr = '0; b1.pwdata = '0;
    b0.psel = 0; b0.penable = 0; b0.pwrite = 0;
    b0.paddr = '0; b0.pwdata = '0;
`ifdef APB_CSR_PSTRB_EN
    b1.pstrb = '0;
    b0.pstrb = 4'hF;
`endif

    add(vecs, 0, 16'h0000, 0, 4'h0, 32'h0, 0, 8'h00);
    add(vecs, 1, 16'h0004, 32'hA5A5_0001, 4'hF, 0, 0, 8'h02);
    add(vecs, 0, 16'h0004, 0, 4'h0, 32'hA5A5_0001, 0, 8'h00);
    add(vecs, 0, 16'h0020, 0, 4'h0, 32'hDEAD_BEEF, 0, 8'h00);
    add(vecs, 1, 16'h0020, 32'h1234_5678, 4'hF, 0, 1, 8'h00);
    add(vecs, 0, 16'h0020, 0, 4'h0, 32'hDEAD_BEEF, 0, 8'h00);
    add(vecs, 0, 16'h0024, 0, 4'h0, 32'h1234_5678, 0, 8'h00);
    add(vecs, 0, 16'h0030, 0, 4'h0, 32'h0, 1, 8'h00);
    add(vecs, 1, 16'h0002, 32'hFFFF_FFFF, 4'hF, 0, 1, 8'h00);
    add(vecs, 0, 16'h0000, 0, 4'h0, 32'h0, 0, 8'h00);
    add(vecs, 1, 16'h001C, 32'hFFFF_0000, 4'hF, 0, 0, 8'h80);
    add(vecs, 0, 16'h001C, 0, 4'h0, 32'hFFFF_0000, 0, 8'h00);
    add(vecs, 0, 16'h002C, 0, 4'h0, 32'h0BAD_F00D, 0, 8'h00);
    add(vecs, 0, 16'h0006, 0, 4'h0, 32'h0, 1, 8'h00);
    add(vecs, 1, 16'h0004, 32'hA5A5_0001, 4'hF, 0, 0, 8'h02);
    add(vecs, 1, 16'h0008, 32'h1122_3344, 4'hF, 0, 0, 8'h04);
    add(vecs, 0, 16'h0008, 0, 4'h0, 32'h1122_3344, 0, 8'h00);
    add(vecs, 1, 16'hFFFC, 32'h0000_0001, 4'hF, 0, 1, 8'h00);
    add(vecs, 0, 16'h0028, 0, 4'h0, 32'hCAFE_0002, 0, 8'h00);

    add(svecs, 1, 16'h0008, 32'h1122_3344, 4'hF, 0, 0, 8'h04);
    add(svecs, 1, 16'h0008, 32'hAABB_CCDD, 4'h5, 0, 0, 8'h04);
    add(svecs, 0, 16'h0008, 0, 4'h0, 32'h11BB_33DD, 0, 8'h00);
    add(svecs, 1, 16'h0008, 32'h9999_9999, 4'h0, 0, 0, 8'h00);
    add(svecs, 0, 16'h0008, 0, 4'h1, 32'h0, 1, 8'h00);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", {31'b0, b1.pready}, 32'h0);
    chk("rst_pslverr", {31'b0, b1.pslverr}, 32'h0);
    chk("rst_prdata", b1.prdata, 32'h0);
    chk("rst_pulse", {24'b0, pulse1}, 32'h0);
    chk_cfg();
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Abort: drop psel in the first ACCESS cycle
    @(posedge clk); #1;
    b1.psel = 1; b1.penable = 0; b1.pwrite = 1;
    b1.paddr = 16'h000C; b1.pwdata = 32'h5555_5555;
`ifdef APB_CSR_PSTRB_EN
    b1.pstrb = 4'hF;
`endif
    @(posedge clk); #1;
    b1.penable = 1;
    @(negedge clk);
    chk("abort_wait", {31'b0, b1.pready}, 32'h0);
    @(posedge clk); #1;
    b1.psel = 0; b1.penable = 0;
    @(negedge clk);
    chk("abort_pulse", {24'b0, pulse1}, 32'h0);
    @(negedge clk);
    chk_cfg();
    xfer(0, 16'h000C, 0, 4'h0, 32'h0, 0);

    // penable without a SETUP phase is ignored
    @(posedge clk); #1;
    b1.psel = 1; b1.penable = 1; b1.pwrite = 0;
    b1.paddr = 16'h0004;
`ifdef APB_CSR_PSTRB_EN
    b1.pstrb = 4'h0;
`endif
    idle_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      idle_rdy = idle_rdy | b1.pready;
    end
    chk("idle_penable", {31'b0, idle_rdy}, 32'h0);
    @(posedge clk); #1;
    b1.psel = 0; b1.penable = 0;

    // Reset asserted mid-ACCESS
    @(posedge clk); #1;
    b1.psel = 1; b1.penable = 0; b1.pwrite = 1;
    b1.paddr = 16'h0004; b1.pwdata = 32'h0000_0077;
`ifdef APB_CSR_PSTRB_EN
    b1.pstrb = 4'hF;
`endif
    @(posedge clk); #1;
    b1.penable = 1;
    rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    @(negedge clk);
    chk("mid_rst_pready", {31'b0, b1.pready}, 32'h0);
    chk("mid_rst_pslverr", {31'b0, b1.pslverr}, 32'h0);
    chk("mid_rst_prdata", b1.prdata, 32'h0);
    chk("mid_rst_pulse", {24'b0, pulse1}, 32'h0);
    chk_cfg();
    @(posedge clk); #1;
    rst = 0;
    b1.psel = 0; b1.penable = 0;
    xfer(0, 16'h0004, 0, 4'h0, 32'h0, 0);

`ifdef APB_CSR_PSTRB_EN
    foreach (svecs[k]) run_vec(svecs[k]);
`else
    if (svecs.size() != 5) $display("note: strobe table");
`endif

    // Back-to-back writes with zero wait states
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      b0.psel = 1; b0.penable = 0; b0.pwrite = 1;
      b0.paddr = 16'(k * 4);
      b0.pwdata = 32'h100 + 32'(k);
      @(negedge clk);
      chk("b2b_setup", {31'b0, b0.pready}, 32'h0);
      if (k > 0) begin
        chk("b2b_pulse", {24'b0, pulse0},
            32'h1 << (k - 1));
      end
      @(posedge clk); #1;
      b0.penable = 1;
      @(negedge clk);
      chk("b2b_ready", {31'b0, b0.pready}, 32'h1);
      chk("b2b_err", {31'b0, b0.pslverr}, 32'h0);
    end
    @(posedge clk); #1;
    b0.psel = 0; b0.penable = 0;
    @(negedge clk);
    chk("b2b_pulse2", {24'b0, pulse0}, 32'h4);
    chk("b2b_cfg0", cfg0[31:0], 32'h100);
    chk("b2b_cfg1", cfg0[63:32], 32'h101);
    chk("b2b_cfg2", cfg0[95:64], 32'h102);
    chk("b2b_cfg3", cfg0[127:96], 32'h0);

    repeat (2) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_left: got %0d expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
